// File: rtl/fpga_run_ctrl_pkg.sv
// rtl/fpga_run_ctrl_pkg.sv - shared types, LED map and helpers for the FPGA run sequencer
package fpga_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET_HOLD = 3'd0,
        ST_BOOT_WAIT  = 3'd1,
        ST_RUN        = 3'd2,
        ST_PASS       = 3'd3,
        ST_FAIL       = 3'd4,
        ST_TIMEOUT    = 3'd5
    } run_state_e;

    localparam int LED_PASS    = 0;
    localparam int LED_FAIL    = 1;
    localparam int LED_RUN     = 2;
    localparam int LED_TIMEOUT = 3;
    localparam int LED_ACT     = 4;
    localparam int LED_HEART   = 5;
    localparam int LED_REQ     = 6;
    localparam int LED_ALIVE   = 7;

    localparam logic [31:0] TIMEOUT_EXIT_CODE = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fpga_run_ctrl_btn_debounce.sv
// rtl/fpga_run_ctrl_btn_debounce.sv - button synchronizer and debounce filter
module btn_debounce
    import fpga_run_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_ni,
    output logic level_o
);

    logic        sync1_q, sync2_q;
    logic        level_q, level_d;
    logic [31:0] cnt_q, cnt_d;

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == DEBOUNCE_CYCLES - 1) begin
                level_d = sync2_q;
            end else begin
                cnt_d = sat_inc(cnt_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_ni;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/fpga_run_ctrl.sv
// rtl/fpga_run_ctrl.sv - boot/run sequencer, watchdog and LED driver for the core test wrapper
module fpga_run_ctrl
    import fpga_run_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES    = 250000,
    parameter int unsigned RESET_HOLD_CYCLES  = 16,
    parameter int unsigned BOOT_DELAY_CYCLES  = 16,
    parameter int unsigned WATCHDOG_CYCLES    = 2**24,
    parameter int unsigned BLINK_HALF_CYCLES  = 12500000,
    parameter int unsigned ACT_STRETCH_CYCLES = 2500000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        btn_rst_ni,
    output logic        core_rst_no,
    output logic        fetch_enable_o,
    input  logic        tests_passed_i,
    input  logic        tests_failed_i,
    input  logic        exit_valid_i,
    input  logic [31:0] exit_value_i,
    input  logic        instr_req_i,
    input  logic        instr_gnt_i,
    output logic [2:0]  state_o,
    output logic [31:0] exit_value_o,
    output logic        done_o,
    output logic [7:0]  led_o
);

    localparam logic [2:0] S_RESET_HOLD = ST_RESET_HOLD;
    localparam logic [2:0] S_BOOT_WAIT  = ST_BOOT_WAIT;
    localparam logic [2:0] S_RUN        = ST_RUN;
    localparam logic [2:0] S_PASS       = ST_PASS;
    localparam logic [2:0] S_FAIL       = ST_FAIL;
    localparam logic [2:0] S_TIMEOUT    = ST_TIMEOUT;

    logic        btn_level;
    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d, wd_q, wd_d, exit_q, exit_d;
    logic [31:0] act_q, act_d, hb_cnt_q, hb_cnt_d;
    logic        hb_q, hb_d, rstn_q, fe_q, done_q, req_q;
    logic        fail_hit, pass_hit, wd_expired;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_ni  (btn_rst_ni),
        .level_o (btn_level)
    );

    assign fail_hit   = tests_failed_i || (exit_valid_i && (exit_value_i != 32'd0));
    assign pass_hit   = tests_passed_i || (exit_valid_i && (exit_value_i == 32'd0));
    assign wd_expired = (WATCHDOG_CYCLES != 0) && !instr_gnt_i && (wd_q == WATCHDOG_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET_HOLD: if (cnt_q == RESET_HOLD_CYCLES - 1) state_d = S_BOOT_WAIT;
            S_BOOT_WAIT:  if (cnt_q == BOOT_DELAY_CYCLES - 1) state_d = S_RUN;
            S_RUN: begin
                if (fail_hit)        state_d = S_FAIL;
                else if (pass_hit)   state_d = S_PASS;
                else if (wd_expired) state_d = S_TIMEOUT;
            end
            S_PASS, S_FAIL, S_TIMEOUT: state_d = state_q;
            default: state_d = S_RESET_HOLD;
        endcase
        // A debounced press overrides every other transition.
        if (!btn_level) state_d = S_RESET_HOLD;
    end

    always_comb begin
        cnt_d = (!btn_level || (state_d != state_q)) ? 32'd0 : sat_inc(cnt_q);
        wd_d  = (state_q == S_RUN && state_d == S_RUN && !instr_gnt_i) ? sat_inc(wd_q) : 32'd0;

        exit_d = exit_q;
        if (state_d == S_RESET_HOLD) begin
            exit_d = '0;
        end else if (state_q == S_RUN && state_d != S_RUN) begin
            if (exit_valid_i)           exit_d = exit_value_i;
            else if (state_d == S_PASS) exit_d = 32'd0;
            else if (state_d == S_FAIL) exit_d = 32'd1;
            else                        exit_d = TIMEOUT_EXIT_CODE;
        end

        if (instr_gnt_i)       act_d = ACT_STRETCH_CYCLES;
        else if (act_q != 0)   act_d = act_q - 32'd1;
        else                   act_d = '0;

        hb_d = hb_q;
        if (hb_cnt_q == BLINK_HALF_CYCLES - 1) begin
            hb_cnt_d = '0;
            hb_d     = ~hb_q;
        end else begin
            hb_cnt_d = sat_inc(hb_cnt_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_RESET_HOLD;
            cnt_q    <= '0;
            wd_q     <= '0;
            exit_q   <= '0;
            act_q    <= '0;
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
            rstn_q   <= 1'b0;
            fe_q     <= 1'b0;
            done_q   <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wd_q     <= wd_d;
            exit_q   <= exit_d;
            act_q    <= act_d;
            hb_cnt_q <= hb_cnt_d;
            hb_q     <= hb_d;
            rstn_q   <= (state_d != S_RESET_HOLD);
            fe_q     <= (state_d == S_RUN) || (state_d == S_PASS) ||
                        (state_d == S_FAIL) || (state_d == S_TIMEOUT);
            done_q   <= (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
            req_q    <= instr_req_i;
        end
    end

    always_comb begin
        led_o              = '0;
        led_o[LED_PASS]    = (state_q == S_PASS);
        led_o[LED_FAIL]    = (state_q == S_FAIL);
        led_o[LED_RUN]     = (state_q == S_RUN);
        led_o[LED_TIMEOUT] = (state_q == S_TIMEOUT);
        led_o[LED_ACT]     = (act_q != 0);
        led_o[LED_HEART]   = hb_q;
        led_o[LED_REQ]     = req_q;
        led_o[LED_ALIVE]   = 1'b1;
    end

    assign state_o        = state_q;
    assign core_rst_no    = rstn_q;
    assign fetch_enable_o = fe_q;
    assign done_o         = done_q;
    assign exit_value_o   = exit_q;

endmodule

// File: tb/tb_fpga_run_ctrl.sv
// tb/tb_fpga_run_ctrl.sv - directed self-checking bench for fpga_run_ctrl
module tb_fpga_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_i, btn_rst_ni, core_rst_no, fetch_enable_o;
    logic        tests_passed_i, tests_failed_i, exit_valid_i;
    logic [31:0] exit_value_i, exit_value_o;
    logic        instr_req_i, instr_gnt_i, done_o;
    logic [2:0]  state_o;
    logic [7:0]  led_o;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    fpga_run_ctrl #(
        .DEBOUNCE_CYCLES(4), .RESET_HOLD_CYCLES(8), .BOOT_DELAY_CYCLES(4),
        .WATCHDOG_CYCLES(32), .BLINK_HALF_CYCLES(10), .ACT_STRETCH_CYCLES(5)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .btn_rst_ni(btn_rst_ni), .core_rst_no(core_rst_no),
        .fetch_enable_o(fetch_enable_o), .tests_passed_i(tests_passed_i),
        .tests_failed_i(tests_failed_i), .exit_valid_i(exit_valid_i),
        .exit_value_i(exit_value_i), .instr_req_i(instr_req_i), .instr_gnt_i(instr_gnt_i),
        .state_o(state_o), .exit_value_o(exit_value_o), .done_o(done_o), .led_o(led_o)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go_run();
        rst_i = 1'b1; btn_rst_ni = 1'b1; tests_passed_i = 0; tests_failed_i = 0;
        exit_valid_i = 0; exit_value_i = '0; instr_req_i = 0; instr_gnt_i = 0;
        tick(2);
        rst_i = 1'b0;
        tick(12);
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL go_run_state: got %0d expected 2", state_o); end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; btn_rst_ni = 1'b1; tests_passed_i = 0; tests_failed_i = 0;
        exit_valid_i = 0; exit_value_i = '0; instr_req_i = 0; instr_gnt_i = 0;
        tick(3);
        n_checks++; if (led_o !== 8'h80) begin n_fail++; $display("FAIL reset_led: got %h expected 80", led_o); end
        n_checks++; if ({core_rst_no, fetch_enable_o, done_o, state_o} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {core_rst_no, fetch_enable_o, done_o, state_o}); end
        n_checks++; if (exit_value_o !== 32'd0) begin n_fail++; $display("FAIL reset_exit: got %h expected 0", exit_value_o); end
        rst_i = 1'b0;
        tick(7);
        n_checks++; if (core_rst_no !== 1'b0) begin n_fail++; $display("FAIL boot_rstn_c7: got %b expected 0", core_rst_no); end
        tick(1);
        n_checks++; if (core_rst_no !== 1'b1 || state_o !== 3'd1) begin n_fail++; $display("FAIL boot_rstn_c8: got %b/%0d expected 1/1", core_rst_no, state_o); end
        tick(1);
        n_checks++; if (led_o[5] !== 1'b0) begin n_fail++; $display("FAIL heart_c9: got %b expected 0", led_o[5]); end
        tick(1);
        n_checks++; if (led_o[5] !== 1'b1) begin n_fail++; $display("FAIL heart_c10: got %b expected 1", led_o[5]); end
        tick(1);
        n_checks++; if (fetch_enable_o !== 1'b0) begin n_fail++; $display("FAIL boot_fe_c11: got %b expected 0", fetch_enable_o); end
        tick(1);
        n_checks++; if (fetch_enable_o !== 1'b1 || state_o !== 3'd2 || led_o[2] !== 1'b1) begin n_fail++; $display("FAIL boot_run_c12: got fe=%b st=%0d led2=%b expected 1/2/1", fetch_enable_o, state_o, led_o[2]); end
    endtask

    task automatic test_pass();
        go_run();
        exit_valid_i = 1; exit_value_i = 32'd0; tick(1); exit_valid_i = 0;
        n_checks++; if (state_o !== 3'd3 || done_o !== 1'b1 || led_o[0] !== 1'b1) begin n_fail++; $display("FAIL pass_state: got st=%0d done=%b led0=%b expected 3/1/1", state_o, done_o, led_o[0]); end
        n_checks++; if (exit_value_o !== 32'd0 || fetch_enable_o !== 1'b1) begin n_fail++; $display("FAIL pass_exit: got %h fe=%b expected 0/1", exit_value_o, fetch_enable_o); end
        tests_failed_i = 1; tick(1); tests_failed_i = 0; tick(1);
        n_checks++; if (state_o !== 3'd3 || exit_value_o !== 32'd0) begin n_fail++; $display("FAIL pass_sticky: got st=%0d exit=%h expected 3/0", state_o, exit_value_o); end
    endtask

    task automatic test_fail();
        go_run();
        tests_passed_i = 1; tests_failed_i = 1; tick(1); tests_passed_i = 0; tests_failed_i = 0;
        n_checks++; if (state_o !== 3'd4 || exit_value_o !== 32'd1 || led_o[1] !== 1'b1) begin n_fail++; $display("FAIL fail_both: got st=%0d exit=%h led1=%b expected 4/1/1", state_o, exit_value_o, led_o[1]); end
        go_run();
        exit_valid_i = 1; exit_value_i = 32'h2A; tick(1); exit_valid_i = 0;
        n_checks++; if (state_o !== 3'd4 || exit_value_o !== 32'h2A) begin n_fail++; $display("FAIL fail_code: got st=%0d exit=%h expected 4/2a", state_o, exit_value_o); end
    endtask

    task automatic test_timeout();
        go_run();
        tick(31);
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL wd_c31: got %0d expected 2", state_o); end
        tick(1);
        n_checks++; if (state_o !== 3'd5 || exit_value_o !== 32'hFFFF_FFFF || led_o[3] !== 1'b1 || done_o !== 1'b1) begin n_fail++; $display("FAIL wd_c32: got st=%0d exit=%h led3=%b done=%b expected 5/ffffffff/1/1", state_o, exit_value_o, led_o[3], done_o); end
        go_run();
        tick(31);
        exit_valid_i = 1; exit_value_i = 32'd0; tick(1); exit_valid_i = 0;
        n_checks++; if (state_o !== 3'd3 || exit_value_o !== 32'd0) begin n_fail++; $display("FAIL exit_beats_wd: got st=%0d exit=%h expected 3/0", state_o, exit_value_o); end
    endtask

    task automatic test_watchdog_kick();
        go_run();
        for (int i = 0; i < 5; i++) begin
            tick(19);
            instr_gnt_i = 1; tick(1); instr_gnt_i = 0;
            n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL wd_kick_%0d: got %0d expected 2", i, state_o); end
        end
    endtask

    task automatic test_button();
        go_run();
        tests_passed_i = 1; tick(1); tests_passed_i = 0;
        for (int i = 0; i < 4; i++) begin
            btn_rst_ni = 0; tick(2); btn_rst_ni = 1; tick(2);
        end
        tick(4);
        n_checks++; if (state_o !== 3'd3 || core_rst_no !== 1'b1) begin n_fail++; $display("FAIL bounce: got st=%0d rstn=%b expected 3/1", state_o, core_rst_no); end
        btn_rst_ni = 0; tick(6);
        n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL press_c6: got %0d expected 3", state_o); end
        tick(1);
        n_checks++; if (state_o !== 3'd0 || core_rst_no !== 1'b0 || fetch_enable_o !== 1'b0 || led_o[0] !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL press_c7: got st=%0d rstn=%b fe=%b led0=%b done=%b expected 0/0/0/0/0", state_o, core_rst_no, fetch_enable_o, led_o[0], done_o); end
        tick(10);
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL press_hold: got %0d expected 0", state_o); end
        btn_rst_ni = 1; tick(13);
        n_checks++; if (core_rst_no !== 1'b0) begin n_fail++; $display("FAIL release_c13: got %b expected 0", core_rst_no); end
        tick(1);
        n_checks++; if (core_rst_no !== 1'b1 || state_o !== 3'd1) begin n_fail++; $display("FAIL release_c14: got %b/%0d expected 1/1", core_rst_no, state_o); end
        tick(3);
        n_checks++; if (fetch_enable_o !== 1'b0) begin n_fail++; $display("FAIL release_c17: got %b expected 0", fetch_enable_o); end
        tick(1);
        n_checks++; if (fetch_enable_o !== 1'b1 || state_o !== 3'd2) begin n_fail++; $display("FAIL release_c18: got %b/%0d expected 1/2", fetch_enable_o, state_o); end
    endtask

    task automatic test_leds();
        logic prev;
        bit   found;
        go_run();
        instr_gnt_i = 1; tick(1); instr_gnt_i = 0;
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (led_o[4] !== 1'b1) begin n_fail++; $display("FAIL act_on_%0d: got %b expected 1", i, led_o[4]); end
            if (i < 4) tick(1);
        end
        tick(1);
        n_checks++; if (led_o[4] !== 1'b0) begin n_fail++; $display("FAIL act_off: got %b expected 0", led_o[4]); end
        instr_gnt_i = 1; tick(1); instr_gnt_i = 0; tick(1);
        instr_gnt_i = 1; tick(1); instr_gnt_i = 0;
        tick(4);
        n_checks++; if (led_o[4] !== 1'b1) begin n_fail++; $display("FAIL act_ext_on: got %b expected 1", led_o[4]); end
        tick(1);
        n_checks++; if (led_o[4] !== 1'b0) begin n_fail++; $display("FAIL act_ext_off: got %b expected 0", led_o[4]); end
        instr_req_i = 1; tick(1);
        n_checks++; if (led_o[7:6] !== 2'b11) begin n_fail++; $display("FAIL req_led_on: got %b expected 11", led_o[7:6]); end
        instr_req_i = 0; tick(1);
        n_checks++; if (led_o[7:6] !== 2'b10) begin n_fail++; $display("FAIL req_led_off: got %b expected 10", led_o[7:6]); end
        prev = led_o[5]; found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            tick(1);
            if (led_o[5] !== prev) found = 1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL heart_seek: got no toggle expected toggle within 12 cycles"); end
        prev = led_o[5];
        tick(9);
        n_checks++; if (led_o[5] !== prev) begin n_fail++; $display("FAIL heart_hold: got %b expected %b", led_o[5], prev); end
        tick(1);
        n_checks++; if (led_o[5] !== ~prev) begin n_fail++; $display("FAIL heart_toggle: got %b expected %b", led_o[5], ~prev); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_watchdog_kick();
        test_button();
        test_leds();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
